retry_buffer: RTL and testbench

Parametrised successor to the single-channel replay buffer in the data-link layer transmit path. Stores every transmitted TLP payload together with its implicitly assigned sequence number. Purges entries on ACK, replays all outstanding entries on NAK or replay-timer expiry, and counts consecutive replays, raising a retrain request when the limit is exceeded. It sits between the TLP source and the link transmitter, alongside the link control FSM.

---
 rtl/retry_pkg.sv | 22 ++
 rtl/retry_ram.sv | 26 ++
 rtl/retry_buffer.sv | 188 ++++++++++++++++++
 tb/tb_retry_buffer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/retry_pkg.sv
// Shared definitions for the data-link retry buffer: DLLP type encoding,
// replay FSM states and modulo sequence arithmetic.
package retry_pkg;

    localparam logic ACK = 1'b0;
    localparam logic NAK = 1'b1;

    typedef enum logic {
        IDLE   = 1'b0,
        REPLAY = 1'b1
    } state_t;

    // Forward distance from b to a, modulo 2^w (w <= 32).
    function automatic logic [31:0] seq_dist(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input int unsigned w);
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        return (a - b) & mask;
    endfunction

endpackage

// File: rtl/retry_ram.sv
// Payload storage: one synchronous write port, one asynchronous read port.
module retry_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Store the accepted payload at the write address.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/retry_buffer.sv
// Transmit-side replay buffer: holds unacknowledged TLPs with implicit sequence
// numbers, purges on ACK, replays on NAK or timer expiry, requests retrain.
module retry_buffer
    import retry_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int SEQ_W      = 12,
    parameter int DEPTH      = 16,
    parameter int MAX_REPLAY = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    wr_valid,
    input  logic [DATA_W-1:0]       wr_data,
    output logic                    wr_ready,
    output logic [SEQ_W-1:0]        wr_seq,
    input  logic                    dllp_valid,
    input  logic                    dllp_nak,
    input  logic [SEQ_W-1:0]        dllp_seq,
    input  logic                    tim_out,
    output logic                    rp_valid,
    output logic [DATA_W-1:0]       rp_data,
    output logic [SEQ_W-1:0]        rp_seq,
    input  logic                    rp_ready,
    output logic                    replaying,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty,
    output logic                    retrain
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int RW = (MAX_REPLAY < 1) ? 1 : $clog2(MAX_REPLAY + 1);
    localparam logic [PW-1:0]    PTR_ONE   = PW'(1);
    localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]    CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0]    CNT_FULL  = CW'(DEPTH);
    localparam logic [SEQ_W-1:0] SEQ_ONE   = SEQ_W'(1);
    localparam logic [RW-1:0]    RCNT_ZERO = RW'(0);
    localparam logic [RW-1:0]    RCNT_ONE  = RW'(1);
    localparam logic [RW-1:0]    RCNT_MAX  = RW'(MAX_REPLAY);

    state_t            state_r, state_n;
    logic [PW-1:0]     head_ptr_r, tail_ptr_r, rp_ptr_r;
    logic [PW-1:0]     head_ptr_n, tail_ptr_n, rp_ptr_n;
    logic [SEQ_W-1:0]  head_seq_r, next_seq_r, head_seq_n, next_seq_n;
    logic [RW-1:0]     replay_cnt_r, replay_cnt_n;
    logic [CW-1:0]     count_r, count_n;
    logic              full_r, empty_r, rp_valid_r, replaying_r, retrain_r, retrain_n;

    logic [SEQ_W-1:0]  d_s;
    logic              purge_s, trigger_s, wr_fire_s, rp_fire_s, rp_last_s;
    logic [CW-1:0]     purge_amt_s, cnt_purged_s;
    logic [PW-1:0]     rp_adv_s, rp_adv_off_s, rp_off_s;

    assign wr_ready  = !full_r && (state_r == IDLE);
    assign wr_fire_s = wr_valid && wr_ready;
    assign rp_fire_s = rp_valid_r && rp_ready;
    assign rp_last_s = (rp_ptr_r == (tail_ptr_r - PTR_ONE));
    assign rp_off_s  = rp_ptr_r - head_ptr_r;

    // Purge amount and replay trigger, evaluated against the post-purge occupancy.
    always_comb begin
        d_s          = SEQ_W'(seq_dist(32'(dllp_seq), 32'(head_seq_r), SEQ_W));
        purge_s      = 1'b0;
        purge_amt_s  = CNT_ZERO;
        if (dllp_valid && (32'(d_s) < 32'(count_r))) begin
            purge_s     = 1'b1;
            purge_amt_s = CW'(d_s) + CNT_ONE;
        end else begin
            purge_s     = 1'b0;
        end
        head_ptr_n   = head_ptr_r + PW'(purge_amt_s);
        head_seq_n   = head_seq_r + SEQ_W'(purge_amt_s);
        cnt_purged_s = count_r - purge_amt_s;
        trigger_s    = ((dllp_valid && (dllp_nak == NAK)) || tim_out) && (cnt_purged_s != CNT_ZERO);
    end

    // Replay FSM next state, replay pointer and consecutive-replay counter.
    always_comb begin
        state_n      = state_r;
        rp_ptr_n     = rp_ptr_r;
        retrain_n    = 1'b0;
        replay_cnt_n = purge_s ? RCNT_ZERO : replay_cnt_r;
        rp_adv_s     = rp_fire_s ? (rp_ptr_r + PTR_ONE) : rp_ptr_r;
        rp_adv_off_s = rp_adv_s - head_ptr_r;
        if (trigger_s) begin
            state_n  = REPLAY;
            rp_ptr_n = head_ptr_n;
            if (replay_cnt_n == RCNT_MAX) begin
                retrain_n    = 1'b1;
                replay_cnt_n = RCNT_ZERO;
            end else begin
                replay_cnt_n = replay_cnt_n + RCNT_ONE;
            end
        end else begin
            case (state_r)
                REPLAY: begin
                    if (cnt_purged_s == CNT_ZERO) begin
                        state_n = IDLE;
                    end else if (rp_fire_s && rp_last_s) begin
                        state_n = IDLE;
                    end else if (purge_s && (CW'(rp_adv_off_s) < purge_amt_s)) begin
                        rp_ptr_n = head_ptr_n;
                    end else begin
                        rp_ptr_n = rp_adv_s;
                    end
                end
                IDLE: begin
                    state_n = IDLE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // Write side: tail pointer, sequence assignment and occupancy.
    always_comb begin
        tail_ptr_n = tail_ptr_r;
        next_seq_n = next_seq_r;
        count_n    = cnt_purged_s;
        if (wr_fire_s) begin
            tail_ptr_n = tail_ptr_r + PTR_ONE;
            next_seq_n = next_seq_r + SEQ_ONE;
            count_n    = cnt_purged_s + CNT_ONE;
        end else begin
            count_n    = cnt_purged_s;
        end
    end

    // State registers and registered status outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            head_ptr_r   <= '0;
            tail_ptr_r   <= '0;
            rp_ptr_r     <= '0;
            head_seq_r   <= '0;
            next_seq_r   <= '0;
            replay_cnt_r <= '0;
            count_r      <= '0;
            full_r       <= 1'b0;
            empty_r      <= 1'b1;
            rp_valid_r   <= 1'b0;
            replaying_r  <= 1'b0;
            retrain_r    <= 1'b0;
        end else begin
            state_r      <= state_n;
            head_ptr_r   <= head_ptr_n;
            tail_ptr_r   <= tail_ptr_n;
            rp_ptr_r     <= rp_ptr_n;
            head_seq_r   <= head_seq_n;
            next_seq_r   <= next_seq_n;
            replay_cnt_r <= replay_cnt_n;
            count_r      <= count_n;
            full_r       <= (count_n == CNT_FULL);
            empty_r      <= (count_n == CNT_ZERO);
            rp_valid_r   <= (state_n == REPLAY);
            replaying_r  <= (state_n == REPLAY);
            retrain_r    <= retrain_n;
        end
    end

    retry_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_fire_s),
        .waddr (tail_ptr_r),
        .wdata (wr_data),
        .raddr (rp_ptr_r),
        .rdata (rp_data)
    );

    assign rp_seq    = head_seq_r + SEQ_W'(rp_off_s);
    assign wr_seq    = next_seq_r;
    assign rp_valid  = rp_valid_r;
    assign replaying = replaying_r;
    assign count     = count_r;
    assign full      = full_r;
    assign empty     = empty_r;
    assign retrain   = retrain_r;

endmodule

// File: tb/tb_retry_buffer.sv
// Directed bench for retry_buffer with a queue scoreboard of outstanding TLPs.
module tb_retry_buffer;

    localparam int DATA_W     = 16;
    localparam int SEQ_W      = 12;
    localparam int DEPTH      = 16;
    localparam int MAX_REPLAY = 3;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              wr_valid = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_ready;
    logic [SEQ_W-1:0]  wr_seq;
    logic              dllp_valid = 1'b0;
    logic              dllp_nak = 1'b0;
    logic [SEQ_W-1:0]  dllp_seq = '0;
    logic              tim_out = 1'b0;
    logic              rp_valid;
    logic [DATA_W-1:0] rp_data;
    logic [SEQ_W-1:0]  rp_seq;
    logic              rp_ready = 1'b0;
    logic              replaying;
    logic [4:0]        count;
    logic              full, empty, retrain;

    always #5 clk = ~clk;

    retry_buffer #(
        .DATA_W(DATA_W), .SEQ_W(SEQ_W), .DEPTH(DEPTH), .MAX_REPLAY(MAX_REPLAY)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready), .wr_seq(wr_seq),
        .dllp_valid(dllp_valid), .dllp_nak(dllp_nak), .dllp_seq(dllp_seq), .tim_out(tim_out),
        .rp_valid(rp_valid), .rp_data(rp_data), .rp_seq(rp_seq), .rp_ready(rp_ready),
        .replaying(replaying), .count(count), .full(full), .empty(empty), .retrain(retrain)
    );

    typedef struct packed {
        logic [SEQ_W-1:0]  seq;
        logic [DATA_W-1:0] data;
    } ent_t;

    ent_t             mq[$];
    logic [SEQ_W-1:0] m_next;
    int               m_rcnt;
    bit               m_replay;
    int               m_rp;
    int               pass_cnt = 0;
    int               total_cnt = 0;
    int               retrain_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        step;
        mq.delete();
        m_next = '0; m_rcnt = 0; m_replay = 1'b0; m_rp = 0;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_wr_seq", wr_seq, 0);
        chk("rst_rp_valid", rp_valid, 0);
        chk("rst_replaying", replaying, 0);
        chk("rst_retrain", retrain, 0);
        reset_n = 1'b1;
    endtask

    // One clock: check presented replay entry, update scoreboard, drive, check status.
    task automatic cycle(input bit wv, input logic [DATA_W-1:0] wd, input bit dv, input bit nak,
                         input logic [SEQ_W-1:0] ds, input bit tmo, input bit rdy);
        int k;
        int adv;
        logic [SEQ_W-1:0] d;
        bit acc, fire, last, trig, exp_rt;
        if (m_replay) begin
            chk("rp_valid_hold", rp_valid, 1);
            chk("rp_seq", rp_seq, mq[m_rp].seq);
            chk("rp_data", rp_data, mq[m_rp].data);
        end
        acc  = wv && !m_replay && (mq.size() < DEPTH);
        fire = m_replay && rdy;
        last = fire && (m_rp == mq.size() - 1);
        k = 0;
        if (dv && mq.size() > 0) begin
            d = ds - mq[0].seq;
            if (int'(d) < mq.size()) k = int'(d) + 1;
        end
        for (int i = 0; i < k; i++) void'(mq.pop_front());
        if (k > 0) m_rcnt = 0;
        trig = ((dv && nak) || tmo) && (mq.size() > 0);
        exp_rt = 1'b0;
        if (trig) begin
            m_replay = 1'b1;
            m_rp = 0;
            if (m_rcnt == MAX_REPLAY) begin
                exp_rt = 1'b1;
                m_rcnt = 0;
            end else begin
                m_rcnt++;
            end
        end else if (m_replay) begin
            if (mq.size() == 0 || last) begin
                m_replay = 1'b0;
            end else begin
                adv = m_rp + (fire ? 1 : 0) - k;
                m_rp = (adv < 0) ? 0 : adv;
            end
        end
        if (acc) begin
            mq.push_back('{seq: m_next, data: wd});
            m_next = m_next + 12'd1;
        end
        wr_valid = wv; wr_data = wd;
        dllp_valid = dv; dllp_nak = nak; dllp_seq = ds;
        tim_out = tmo; rp_ready = rdy;
        step;
        wr_valid = 1'b0; dllp_valid = 1'b0; tim_out = 1'b0; rp_ready = 1'b0;
        chk("count", count, mq.size());
        chk("empty", empty, mq.size() == 0);
        chk("full", full, mq.size() == DEPTH);
        chk("wr_seq", wr_seq, m_next);
        chk("wr_ready", wr_ready, !m_replay && (mq.size() < DEPTH));
        chk("rp_valid", rp_valid, m_replay);
        chk("replaying", replaying, m_replay);
        chk("retrain", retrain, exp_rt);
        if (retrain) retrain_seen++;
    endtask

    task automatic drain;
        while (m_replay) cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_next = '0; m_rcnt = 0; m_replay = 1'b0; m_rp = 0;
        step;
        do_reset;

        // Five writes, ACK 2, then a stale NAK replays what is left.
        for (int i = 0; i < 5; i++) cycle(1'b1, 16'hA000 + 16'(i), 1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("t1_wr_seq", wr_seq, 5);
        chk("t1_count", count, 5);
        cycle(1'b0, '0, 1'b1, 1'b0, 12'd2, 1'b0, 1'b0);
        chk("t1_ack_count", count, 2);
        cycle(1'b0, '0, 1'b1, 1'b1, 12'd2, 1'b0, 1'b0);
        chk("t1_head_seq", rp_seq, 3);
        chk("t1_head_data", rp_data, 16'hA003);
        drain;

        // NAK that purges entry 0 and replays entries 1 and 2.
        do_reset;
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'hB000 + 16'(i), 1'b0, 1'b0, '0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b1, 12'd0, 1'b0, 1'b0);
        chk("t2_rp_valid", rp_valid, 1);
        chk("t2_rp_seq1", rp_seq, 1);
        drain;
        chk("t2_wr_ready", wr_ready, 1);

        // Fill, overflow attempt, then ACK everything.
        do_reset;
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b1, 16'hC000 + 16'(i), 1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("t3_full", full, 1);
        chk("t3_wr_ready", wr_ready, 0);
        chk("t3_count", count, 16);
        cycle(1'b0, '0, 1'b1, 1'b0, 12'd15, 1'b0, 1'b0);
        chk("t3_empty", empty, 1);

        // Four timer expiries without ACK raise exactly one retrain.
        do_reset;
        retrain_seen = 0;
        for (int i = 0; i < 2; i++) cycle(1'b1, 16'hD000 + 16'(i), 1'b0, 1'b0, '0, 1'b0, 1'b0);
        for (int t = 0; t < 4; t++) begin
            cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
            drain;
        end
        chk("t4_retrain_once", retrain_seen, 1);
        cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
        drain;
        chk("t4_retrain_after", retrain_seen, 1);

        // Sequence wrap: advance to 4094 with write+ACK pairs.
        do_reset;
        for (int i = 0; i < 4094; i++)
            cycle(1'b1, 16'(i), i > 0, 1'b0, SEQ_W'(i - 1), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 12'd4093, 1'b0, 1'b0);
        chk("t5_wr_seq", wr_seq, 4094);
        for (int i = 0; i < 4; i++) cycle(1'b1, 16'hE000 + 16'(i), 1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("t5_wr_seq_wrap", wr_seq, 2);
        cycle(1'b0, '0, 1'b1, 1'b0, 12'd0, 1'b0, 1'b0);
        chk("t5_count", count, 1);
        cycle(1'b0, '0, 1'b1, 1'b0, 12'd4000, 1'b0, 1'b0);
        chk("t5_stale", count, 1);
        cycle(1'b0, '0, 1'b1, 1'b1, 12'd4000, 1'b0, 1'b0);
        chk("t5_head_seq", rp_seq, 1);
        chk("t5_head_data", rp_data, 16'hE003);
        drain;

        // ACK of the presented head during a stalled replay, then reset mid-replay.
        do_reset;
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'hF000 + 16'(i), 1'b0, 1'b0, '0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b1, 12'hFFF, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("t6_rp_seq0", rp_seq, 0);
        cycle(1'b0, '0, 1'b1, 1'b0, 12'd0, 1'b0, 1'b0);
        chk("t6_rp_jump", rp_seq, 1);
        chk("t6_rp_jump_data", rp_data, 16'hF001);
        cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        chk("t6_rp_seq2", rp_seq, 2);
        do_reset;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
